// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel one-cycle strobe plus a registered
// divided square wave, with glitch-free runtime divide changes and a global phase restart.
module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       cfg_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_reg, div_nxt;
    logic [DIV_W-1:0] pend, pend_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             ce_q, ce_nxt;
    logic             dclk_q, dclk_nxt;
    logic             err_q, err_nxt;
    logic [DIV_W-1:0] val;
    logic [DIV_W-1:0] new_div;
    logic             load_ok, load_bad, have_new, wrap;

    assign val      = div_val[i*DIV_W +: DIV_W];
    assign load_ok  = div_load[i] && (val >= DIV_MIN);
    assign load_bad = div_load[i] && (val < DIV_MIN);
    // A load on this very edge takes precedence over an older pending value.
    assign have_new = load_ok || pend_vld;
    assign new_div  = load_ok ? val : pend;
    assign wrap     = (cnt == (div_reg - ONE));

    always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      div_nxt      = div_reg;
      pend_nxt     = pend;
      pend_vld_nxt = pend_vld;
      ce_nxt       = 1'b0;
      dclk_nxt     = dclk_q;
      err_nxt      = err_q | load_bad;
      if (load_ok) begin
        pend_nxt     = val;
        pend_vld_nxt = 1'b1;
      end
      case (state)
        IDLE: begin
          cnt_nxt  = '0;
          dclk_nxt = 1'b0;
          if (have_new) begin
            div_nxt      = new_div;
            pend_vld_nxt = 1'b0;
          end
          if (ch_enable[i]) state_nxt = RUN;
        end
        RUN: begin
          if (!ch_enable[i]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            dclk_nxt  = 1'b0;
          end else if (sync_restart) begin
            cnt_nxt  = '0;
            dclk_nxt = 1'b0;
            if (have_new) begin
              div_nxt      = new_div;
              pend_vld_nxt = 1'b0;
            end
          end else if (wrap) begin
            // Divide changes only land here, so every period is whole.
            cnt_nxt  = '0;
            ce_nxt   = 1'b1;
            dclk_nxt = 1'b1;
            if (have_new) begin
              div_nxt      = new_div;
              pend_vld_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + ONE;
            if (cnt_nxt == (div_reg >> 1)) dclk_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        cnt      <= '0;
        div_reg  <= DIV_RST;
        pend     <= '0;
        pend_vld <= 1'b0;
        ce_q     <= 1'b0;
        dclk_q   <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        div_reg  <= div_nxt;
        pend     <= pend_nxt;
        pend_vld <= pend_vld_nxt;
        ce_q     <= ce_nxt;
        dclk_q   <= dclk_nxt;
        err_q    <= err_nxt;
      end
    end

    assign ce_out[i]    = ce_q;
    assign div_clk[i]   = dclk_q;
    assign ch_active[i] = (state == RUN);
    assign cfg_err[i]   = err_q;
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: hand-derived vector table, directed corner sequences and random
// traffic against a time-based reference model (strobe times, not counters).
`timescale 1ns/1ps
module tb_clk_en_gen;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_enable, div_load, ce_out, div_clk, ch_active, cfg_err;
  logic [63:0] div_val;
  logic        sync_restart;

  always #2.5 sysclk = ~sysclk;

  clk_en_gen #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(2)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .ch_enable(ch_enable), .div_val(div_val),
    .div_load(div_load), .sync_restart(sync_restart), .ce_out(ce_out),
    .div_clk(div_clk), .ch_active(ch_active), .cfg_err(cfg_err));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each running channel knows when its next strobe is due.
  int m_now;
  bit m_run[4], m_hs[4], m_ce[4], m_err[4];
  int m_div[4], m_pend[4], m_next[4], m_last[4], m_hi[4];

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  ld;
    logic [15:0] v0;
    logic [15:0] v1;
    logic        rs;
    logic [3:0]  ce;
    logic [3:0]  dk;
    logic [3:0]  act;
    logic [3:0]  err;
  } vec_t;
  vec_t tbl[17];

  logic [3:0]  r_en, r_ld;
  logic [63:0] r_v;
  logic        r_rs;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_hs[i] = 0; m_ce[i] = 0; m_err[i] = 0;
      m_div[i] = 2; m_pend[i] = 0; m_next[i] = 0; m_last[i] = 0; m_hi[i] = 0;
    end
  endtask

  task automatic model_edge();
    int v;
    bit ok;
    m_now++;
    for (int i = 0; i < 4; i++) begin
      v  = int'(div_val[i*16 +: 16]);
      ok = div_load[i] && (v >= 2);
      if (div_load[i] && v < 2) m_err[i] = 1;
      if (ok) m_pend[i] = v;
      m_ce[i] = 0;
      if (!ch_enable[i]) begin
        m_run[i] = 0;
        m_hs[i]  = 0;
      end else if (!m_run[i]) begin
        if (m_pend[i] != 0) begin m_div[i] = m_pend[i]; m_pend[i] = 0; end
        m_run[i]  = 1;
        m_hs[i]   = 0;
        m_next[i] = m_now + m_div[i];
      end else if (sync_restart) begin
        if (m_pend[i] != 0) begin m_div[i] = m_pend[i]; m_pend[i] = 0; end
        m_hs[i]   = 0;
        m_next[i] = m_now + m_div[i];
      end else if (m_now == m_next[i]) begin
        if (m_pend[i] != 0) begin m_div[i] = m_pend[i]; m_pend[i] = 0; end
        m_ce[i]   = 1;
        m_hs[i]   = 1;
        m_last[i] = m_now;
        m_hi[i]   = m_div[i] / 2;
        m_next[i] = m_now + m_div[i];
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] e_ce, e_dk, e_act, e_err;
    for (int i = 0; i < 4; i++) begin
      e_ce[i]  = m_ce[i];
      e_dk[i]  = m_run[i] && m_hs[i] && ((m_now - m_last[i]) < m_hi[i]);
      e_act[i] = m_run[i];
      e_err[i] = m_err[i];
    end
    chk("model_ce_out", ce_out, e_ce);
    chk("model_div_clk", div_clk, e_dk);
    chk("model_ch_active", ch_active, e_act);
    chk("model_cfg_err", cfg_err, e_err);
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] ld, input logic [63:0] v,
                       input logic rs);
    @(negedge sysclk);
    ch_enable = en; div_load = ld; div_val = v; sync_restart = rs;
    @(posedge sysclk);
    if (rst_n) model_edge(); else model_reset();
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; ch_enable = '0; div_load = '0; div_val = '0; sync_restart = 1'b0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    model_reset();
    m_now = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // en, ld, v0, v1, rs | ce, div_clk, active, err  (row k = state after edge k)
    tbl[0]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[3]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[4]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b0001, 16'd5, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[6]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[7]  = '{4'b0001, 4'b0010, 16'd0, 16'd1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    tbl[8]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tbl[9]  = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tbl[10] = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tbl[11] = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    tbl[12] = '{4'b0001, 4'b0010, 16'd0, 16'd4, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    tbl[13] = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tbl[14] = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tbl[15] = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tbl[16] = '{4'b0001, 4'b0000, 16'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

    // Reset state
    reset_dut();
    #1;
    chk("reset_ce_out", ce_out, 4'b0000);
    chk("reset_div_clk", div_clk, 4'b0000);
    chk("reset_ch_active", ch_active, 4'b0000);
    chk("reset_cfg_err", cfg_err, 4'b0000);

    // Default divide, glitch-free reload to 5, illegal load on ch1
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].en, tbl[k].ld, {32'd0, tbl[k].v1, tbl[k].v0}, tbl[k].rs);
      chk($sformatf("tbl%0d_ce_out", k), ce_out, tbl[k].ce);
      chk($sformatf("tbl%0d_div_clk", k), div_clk, tbl[k].dk);
      chk($sformatf("tbl%0d_ch_active", k), ch_active, tbl[k].act);
      chk($sformatf("tbl%0d_cfg_err", k), cfg_err, tbl[k].err);
    end

    // Four channels at 3/4/6/12 with staggered starts, then sync_restart
    reset_dut();
    drive(4'b0000, 4'b1111, {16'd12, 16'd6, 16'd4, 16'd3}, 1'b0);
    check_model();
    drive(4'b0001, 4'b0000, 64'd0, 1'b0); check_model();
    drive(4'b0001, 4'b0000, 64'd0, 1'b0); check_model();
    repeat (2) begin drive(4'b0011, 4'b0000, 64'd0, 1'b0); check_model(); end
    repeat (3) begin drive(4'b0111, 4'b0000, 64'd0, 1'b0); check_model(); end
    repeat (18) begin drive(4'b1111, 4'b0000, 64'd0, 1'b0); check_model(); end
    drive(4'b1111, 4'b0000, 64'd0, 1'b1);
    check_model();
    chk("restart_ce_zero", ce_out, 4'b0000);
    chk("restart_dclk_zero", div_clk, 4'b0000);
    for (int k = 1; k <= 12; k++) begin
      drive(4'b1111, 4'b0000, 64'd0, 1'b0);
      check_model();
      if (k == 3) chk("restart_ch0_at3", {3'b000, ce_out[0]}, 4'b0001);
      if (k == 12) chk("restart_all_at12", ce_out, 4'b1111);
    end

    // Drop ch2 mid-period, then re-enable
    repeat (5) begin drive(4'b1111, 4'b0000, 64'd0, 1'b0); check_model(); end
    drive(4'b1011, 4'b0000, 64'd0, 1'b0);
    check_model();
    chk("disable_ch2_outputs", {1'b0, ce_out[2], div_clk[2], ch_active[2]}, 4'b0000);
    repeat (3) begin drive(4'b1011, 4'b0000, 64'd0, 1'b0); check_model(); end
    for (int k = 0; k <= 6; k++) begin
      drive(4'b1111, 4'b0000, 64'd0, 1'b0);
      check_model();
      chk($sformatf("reenable_ch2_k%0d", k), {3'b000, ce_out[2]}, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // Reset while div_clk is high and a load is pending
    reset_dut();
    drive(4'b0000, 4'b0001, {48'd0, 16'd4}, 1'b0); check_model();
    drive(4'b0001, 4'b0000, 64'd0, 1'b0); check_model();
    repeat (4) begin drive(4'b0001, 4'b0000, 64'd0, 1'b0); check_model(); end
    drive(4'b0001, 4'b0001, {48'd0, 16'd7}, 1'b0);
    check_model();
    chk("pre_reset_dclk_high", {3'b000, div_clk[0]}, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_ce_out", ce_out, 4'b0000);
    chk("async_reset_div_clk", div_clk, 4'b0000);
    chk("async_reset_ch_active", ch_active, 4'b0000);
    chk("async_reset_cfg_err", cfg_err, 4'b0000);
    repeat (2) begin drive(4'b0001, 4'b0000, 64'd0, 1'b0); check_model(); end
    @(negedge sysclk);
    rst_n = 1'b1;
    @(posedge sysclk);
    model_edge();
    #1;
    check_model();
    for (int k = 1; k <= 4; k++) begin
      drive(4'b0001, 4'b0000, 64'd0, 1'b0);
      check_model();
      chk($sformatf("post_reset_default_k%0d", k), {3'b000, ce_out[0]},
          (k % 2 == 0) ? 4'b0001 : 4'b0000);
    end

    // Random traffic against the model
    reset_dut();
    r_en = 4'b1111;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 39) == 0) r_en[i] = ~r_en[i];
        r_ld[i] = ($urandom_range(0, 9) == 0);
        r_v[i*16 +: 16] = 16'($urandom_range(0, 9));
      end
      r_rs = ($urandom_range(0, 29) == 0);
      drive(r_en, r_ld, r_v, r_rs);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
